// File: rtl/linear_spike_accum.sv
// linear_spike_accum
//   Walks the linear-layer weight ROM one output neuron at a time, adding the
//   decoded signed weight of every input whose latched spike bit is set, and
//   presents one saturated membrane sum per neuron on a valid/ready port.
//
// Ports
//   clk        system clock (shared with the weight ROM)
//   rst        asynchronous reset, active-high
//   start      frame start pulse, ignored while busy
//   spike_in   input spike vector, sampled when start is accepted
//   busy       high from the cycle after start up to and including done
//   addrb      weight ROM read address
//   doutb      weight ROM data, valid one cycle after addrb
//   out_valid  out_idx/out_sum valid
//   out_ready  downstream accept
//   out_idx    neuron index being presented
//   out_sum    signed saturated sum for out_idx
//   done       one-cycle pulse after the last result is accepted
module linear_spike_accum #(
  parameter int unsigned ADDR  = 16,
  parameter int unsigned WIDE  = 4,
  parameter int unsigned IN_N  = 256,
  parameter int unsigned OUT_N = 128,
  parameter int unsigned ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IN_N-1:0]          spike_in,
  output logic                     busy,
  output logic [ADDR-1:0]          addrb,
  input  logic [WIDE-1:0]          doutb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(OUT_N)-1:0] out_idx,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     done
);

  localparam int unsigned IW = $clog2(IN_N);
  localparam int unsigned NW = $clog2(OUT_N);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StOut   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [NW-1:0]    neuron_q, neuron_d;
  logic [IW-1:0]    in_q, in_d;
  logic [IN_N-1:0]  spike_q, spike_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  // Delayed valid / spike bit aligned with the registered ROM read.
  logic             vld_q, spk_q;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_sat;

  // The fetch counter stops at IN_N-1 rather than wrapping, so addrb keeps
  // showing the last issued address outside FETCH.
  assign addrb     = ADDR'(neuron_q) * ADDR'(IN_N) + ADDR'(in_q);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign done      = (state_q == StDone);
  assign out_idx   = neuron_q;
  assign out_sum   = acc_q;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - WIDE){doutb[WIDE-1]}}, doutb};
    acc_sat  = sum_wide[ACC_W-1:0];
    // Overflow when the guard bit disagrees with the result sign bit.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    in_d     = in_q;
    spike_d  = spike_q;
    acc_d    = acc_q;
    if (vld_q && spk_q) begin
      acc_d = acc_sat;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          spike_d  = spike_in;
          neuron_d = '0;
          in_d     = '0;
          acc_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (in_q == IW'(IN_N - 1)) begin
          state_d = StDrain;
        end else begin
          in_d = in_q + 1'b1;
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (out_ready) begin
          if (neuron_q == NW'(OUT_N - 1)) begin
            state_d = StDone;
          end else begin
            acc_d    = '0;
            neuron_d = neuron_q + 1'b1;
            in_d     = '0;
            state_d  = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      neuron_q <= '0;
      in_q     <= '0;
      spike_q  <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      spk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      in_q     <= in_d;
      spike_q  <= spike_d;
      acc_q    <= acc_d;
      vld_q    <= (state_q == StFetch);
      spk_q    <= spike_q[in_q];
    end
  end

endmodule

// File: doc/linear_spike_accum.md
Name: linear_spike_accum

Overview:
- Sequencer and accumulator directly downstream of the linear-layer weight ROM (4-bit weight indices, 1-cycle registered read).
- For each output neuron in turn, reads all IN_N weight indices from the ROM and adds the decoded weight for every input whose spike bit is set.
- Presents one signed membrane-sum per neuron on a valid/ready output toward the neuron-update stage.

Parameters:
- ADDR, 16, weight ROM address width; must satisfy OUT_N*IN_N <= 2^ADDR.
- WIDE, 4, weight index width; the index is interpreted as two's-complement (-8..+7 at default).
- IN_N, 256, number of input spikes per frame.
- OUT_N, 128, number of output neurons.
- ACC_W, 16, accumulator and out_sum width, signed.

Ports:
- clk  in  1  system clock; the weight ROM is driven from the same clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a frame; ignored while busy=1.
- spike_in  in  IN_N  input spike vector; sampled only in the cycle start is accepted.
- busy  out  1  high from the accepted start until the done cycle, inclusive.
- addrb  out  ADDR  weight ROM read address.
- doutb  in  WIDE  weight ROM data; valid one cycle after addrb.
- out_valid  out  1  out_sum/out_idx are valid.
- out_ready  in  1  downstream accepts the result when out_valid && out_ready.
- out_idx  out  $clog2(OUT_N)  index of the neuron being presented.
- out_sum  out  ACC_W  signed accumulated sum for out_idx.
- done  out  1  one-cycle pulse after the last neuron's result is accepted.

Behaviour:
- Reset: all outputs are 0 (busy, addrb, out_valid, out_idx, out_sum, done). FSM goes to IDLE; counters, accumulator and the latched spike vector are cleared.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced and no partial result is presented.
- FSM states:
  - IDLE: on start, latch spike_in, set neuron=0 and in=0, go to FETCH. busy rises in the next cycle.
  - FETCH: each cycle drives addrb = neuron*IN_N + in, then increments in. Issues exactly IN_N addresses, in = 0..IN_N-1. After issuing in=IN_N-1, go to DRAIN.
  - DRAIN: one cycle that consumes the final ROM word. Then go to OUT.
  - OUT: out_valid=1, out_idx=neuron, out_sum=acc, all held stable until out_ready.
    - On handshake with neuron<OUT_N-1: clear acc, neuron++, in=0, go to FETCH. The first address of the next neuron is issued in the cycle after the handshake.
    - On handshake with neuron=OUT_N-1: go to DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Read pipeline:
  - A 1-cycle delayed valid flag and delayed spike bit (spike_latched[in]) track each issued address.
  - When the delayed valid is set and the delayed spike bit is 1, acc <= sat(acc + sign_extend(doutb)).
  - When the delayed spike bit is 0, acc is unchanged.
- Saturation: the sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Accumulator: cleared on entry to FETCH for each neuron, so there is no carry-over between neurons or frames.
- Timing: ROM-side latency per neuron is IN_N+1 cycles (FETCH+DRAIN). With out_ready held high, each neuron takes IN_N+2 cycles. addrb holds its last value outside FETCH.
- Boundaries:
  - A start pulse while busy is dropped with no effect.
  - start coinciding with the done cycle is ignored.
  - out_ready asserted while out_valid=0 has no effect.
  - Address arithmetic never wraps for legal parameters.

Test Plan:
- spike_in all 0, any ROM contents, out_ready=1: 128 results, all out_sum=0, out_idx 0..127 in order; done 1 cycle after the last handshake; addrb sweeps 0..32767.
- spike_in all 1, ROM all 4'b0001: every out_sum=256. ROM all 4'b1000: every out_sum=-2048. Per-neuron spacing is 258 cycles with out_ready=1.
- spike_in only bit 5 set, ROM word n*256+5 = 4'b0111 for neuron n, all other words = 4'b1111: every out_sum=+7. Toggling bit 5 alone produces 0.
- Saturation with ACC_W=8, IN_N=64, all spikes, ROM all +7: out_sum=127 (not 448 wrapped). With ROM all -8: out_sum=-128.
- Backpressure: hold out_ready=0 for 20 cycles at neuron 3 -> out_valid, out_idx=3 and out_sum stay stable, addrb does not advance, and no extra accumulation occurs. Results must match the no-stall run.
- Assert rst for 1 cycle during neuron 10 FETCH -> all outputs 0 next cycle, no done pulse. A fresh start produces a correct full frame. A start pulse while busy is ignored, with results identical to the run without it.
